// File: rtl/comp_pkg.sv
// Shared types and sizing helpers for the sequential digit-serial comparator.
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit operand still needs a 1-bit index register.
    function automatic int calc_idx_w(input int width, input int digit);
        int ndig;
        ndig = width / digit;
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice; NOR-only for DIGIT <= 2.
module cmp_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    if (DIGIT == 1) begin : g_nor1
        logic nx, ny;
        assign nx = ~(x[0] | x[0]);
        assign ny = ~(y[0] | y[0]);
        assign gt = ~(nx | y[0]);
        assign lt = ~(x[0] | ny);
        assign eq = ~(gt | lt);
    end else if (DIGIT == 2) begin : g_nor2
        logic nx1, ny1, nx0, ny0;
        logic gt1, lt1, eq1, gt0, lt0;
        logic neq1, ngt0, nlt0, gt_lo, lt_lo, ngt, nlt;
        assign nx1  = ~(x[1] | x[1]);
        assign ny1  = ~(y[1] | y[1]);
        assign nx0  = ~(x[0] | x[0]);
        assign ny0  = ~(y[0] | y[0]);
        assign gt1  = ~(nx1 | y[1]);
        assign lt1  = ~(x[1] | ny1);
        assign eq1  = ~(gt1 | lt1);
        assign gt0  = ~(nx0 | y[0]);
        assign lt0  = ~(x[0] | ny0);
        assign neq1 = ~(eq1 | eq1);
        assign ngt0 = ~(gt0 | gt0);
        assign nlt0 = ~(lt0 | lt0);
        // Low bit only decides when the high bits tie.
        assign gt_lo = ~(neq1 | ngt0);
        assign lt_lo = ~(neq1 | nlt0);
        assign ngt  = ~(gt1 | gt_lo);
        assign nlt  = ~(lt1 | lt_lo);
        assign gt   = ~(ngt | ngt);
        assign lt   = ~(nlt | nlt);
        assign eq   = ~(gt | lt);
    end else begin : g_wide
        assign gt = (x > y);
        assign lt = (x < y);
        assign eq = (x == y);
    end

endmodule

// File: rtl/comp_nbit_seq.sv
// Digit-serial MSB-first magnitude comparator with early exit and valid/ready handshakes.
module comp_nbit_seq
    import comp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    input  logic                          is_signed,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          l,
    output logic                          e,
    output logic                          g,
    output logic [$clog2(WIDTH/DIGIT):0]  cycles
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int IDX_W = calc_idx_w(WIDTH, DIGIT);
    localparam int CNT_W = $clog2(NDIG) + 1;

    if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("comp_nbit_seq: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic               l_q, l_d;
    logic               e_q, e_d;
    logic               g_q, g_d;

    logic [WIDTH-1:0]   sign_mask;
    logic [DIGIT-1:0]   a_dig, b_dig;
    logic               dig_lt, dig_eq, dig_gt;

    always_comb begin
        a_dig = DIGIT'(a_q >> (int'(idx_q) * DIGIT));
        b_dig = DIGIT'(b_q >> (int'(idx_q) * DIGIT));
    end

    cmp_digit #(.DIGIT(DIGIT)) u_cmp_digit (
        .x  (a_dig),
        .y  (b_dig),
        .lt (dig_lt),
        .eq (dig_eq),
        .gt (dig_gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            cycles_q <= '0;
            l_q      <= 1'b0;
            e_q      <= 1'b0;
            g_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            cycles_q <= cycles_d;
            l_q      <= l_d;
            e_q      <= e_d;
            g_q      <= g_d;
        end
    end

    // Flipping the sign bit maps two's complement onto offset binary, so CMP stays unsigned.
    always_comb begin
        sign_mask            = '0;
        sign_mask[WIDTH-1]   = is_signed;
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        cycles_d = cycles_q;
        l_d      = l_q;
        e_d      = e_q;
        g_d      = g_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a ^ sign_mask;
                    b_d      = b ^ sign_mask;
                    idx_d    = IDX_W'(NDIG - 1);
                    cycles_d = '0;
                    state_d  = CMP;
                end
            end
            CMP: begin
                cycles_d = cycles_q + CNT_W'(1);
                if (dig_gt) begin
                    {l_d, e_d, g_d} = 3'b001;
                    state_d         = DONE;
                end else if (dig_lt) begin
                    {l_d, e_d, g_d} = 3'b100;
                    state_d         = DONE;
                end else if (dig_eq && (idx_q == '0)) begin
                    {l_d, e_d, g_d} = 3'b010;
                    state_d         = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        l         = l_q;
        e         = e_q;
        g         = g_q;
        cycles    = cycles_q;
    end

endmodule

// File: doc/comp_nbit_seq.md
Name: comp_nbit_seq

Overview:
- Parametrised, sequential successor to the 2-bit gate-level comparators.
- Compares two WIDTH-bit operands, examining DIGIT bits per clock, MSB-first.
- Stops early at the first differing digit.
- Supports unsigned and two's-complement modes.
- Uses valid/ready handshakes on input and output, so it can sit between a register-file/ALU front end and downstream control logic.

Parameters:
- WIDTH, 8: operand width in bits. Must be at least 1.
- DIGIT, 2: bits compared per cycle. Must divide WIDTH exactly; otherwise elaboration fails.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- l  out  1  A < B.
- e  out  1  A == B.
- g  out  1  A > B.
- cycles  out  clog2(NDIG)+1  number of digits examined for the current result.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, l=e=g=0, cycles=0, internal operand registers=0.
- NDIG = WIDTH/DIGIT. The digit index idx runs from NDIG-1 (most significant digit) down to 0.
- States: IDLE, CMP, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is high: capture a and b. If is_signed=1, invert bit WIDTH-1 of both captured values (offset-binary mapping), so CMP logic is always unsigned.
  - On capture: set idx=NDIG-1, clear cycles, go to CMP.
- CMP:
  - in_ready=0.
  - Each cycle, compare digit idx of A against digit idx of B, unsigned, and increment cycles.
  - A digit > B digit: set g=1, l=0, e=0; go to DONE.
  - A digit < B digit: set l=1, g=0, e=0; go to DONE.
  - Digits equal and idx==0: set e=1, l=0, g=0; go to DONE.
  - Digits equal and idx>0: decrement idx, stay in CMP.
- DONE:
  - out_valid=1, in_ready=0.
  - l, e, g and cycles stay stable until out_ready is high.
  - On out_valid && out_ready: go to IDLE and drop out_valid. l, e, g and cycles keep the last result until the next result is written.
- Invariant: whenever out_valid=1, exactly one of l, e, g is 1.
- Latency: acceptance edge -> out_valid high after k clocks, where k = digits examined (1..NDIG).
- Throughput: a new operand pair is accepted no earlier than the cycle after the result handshake. Acceptance is never combined with the result handshake in the same cycle.
- a, b and is_signed are sampled only at the acceptance edge. Changes while busy are ignored.
- in_valid in CMP/DONE is ignored, with no loss of state. The producer must hold in_valid until in_ready is high.
- Reset asserted mid-CMP or mid-DONE: immediately return to reset values; the in-flight result is discarded.
- Signed corner cases: 0x80 vs 0x7F (WIDTH=8) gives l when signed and g when unsigned. Equal operands give e in both modes.

Decomposition:
- Shared package comp_pkg holds:
  - the state enum (IDLE, CMP, DONE), 2-bit encoding;
  - a function computing NDIG and the index width from WIDTH/DIGIT.
- One combinational sub-module, cmp_digit (parameter DIGIT):
  - inputs: two DIGIT-bit values;
  - outputs: lt, eq, gt.
  - For DIGIT≤2 it is structured as NOR-only logic, consistent with the gate-level comparator family.
- The top module holds the FSM, operand registers, index counter and handshakes.

Test Plan:
- Unsigned equal, WIDTH=8, DIGIT=2: a=0xA5, b=0xA5, is_signed=0 -> out_valid after 4 cycles; e=1, l=0, g=0, cycles=4.
- Early exit: a=0x80, b=0x7F, is_signed=0 -> out_valid after 1 cycle; g=1, cycles=1. Repeat with is_signed=1 -> l=1, cycles=1.
- Late difference: a=0x03, b=0x02, unsigned -> g=1 after 4 cycles. Then a=0xFE, b=0xFF, signed (-2 vs -1) -> l=1 after 4 cycles.
- Backpressure: out_ready held 0 for 10 cycles after a result -> out_valid, l, e, g stay stable and in_ready stays 0. Pulsing in_valid with new operands has no effect. out_ready=1 -> in_ready=1 on the next cycle.
- Reset mid-operation: drop rst_n during the 2nd CMP cycle -> out_valid=0, l=e=g=0 and in_ready=1 immediately (asynchronously). A fresh compare after release gives the correct result.
- Exhaustive sweep: WIDTH=4 with DIGIT=1, 2 and 4; all 256 pairs in both modes -> l/e/g match a reference model and cycles equals the leading-equal-digit count + 1, capped at NDIG.
